mux_sync_launcher: RTL and testbench

- Source-side launcher for the mux-recirculation (mux + N-flop) clock-domain-crossing synchronizer.
- Accepts words with a valid/ready handshake in the source clock domain.
- Registers each accepted word and drives a data bus plus a qualifying en pulse. Both are held stable long enough for the destination-side mux synchronizer to capture them safely.
- Two operating modes, selected by USE_ACK:
  - Open-loop fixed hold/gap timing.
  - Closed-loop 4-phase handshake that uses an ack returned from the destination domain.

---
 rtl/mux_sync_launcher.sv | 123 ++++++++++++
 tb/tb_mux_sync_launcher.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_sync_launcher.sv
// Source-side launcher for a mux-recirculation CDC synchronizer.
// Accepts words on a valid/ready handshake and presents them as a registered
// data bus qualified by en, held long enough for the destination to capture.
// USE_ACK = 0: open-loop IDLE -> HOLD -> GAP -> IDLE timing.
// USE_ACK = 1: 4-phase handshake IDLE -> REQ -> RELEASE -> IDLE on ack.
//
// Ports:
//   clka      source clock
//   rstn      asynchronous active-low reset
//   in_valid  upstream word valid
//   in_ready  block can accept (decoded from state, IDLE only)
//   in_data   upstream word
//   ack       asynchronous ack level from destination (closed-loop only)
//   en        registered qualifier to destination synchronizer
//   data      registered data to destination synchronizer
//   done      one-cycle pulse when a transfer completes
module mux_sync_launcher #(
    parameter int unsigned DW          = 8,
    parameter int unsigned HOLD        = 12,
    parameter int unsigned GAP         = 6,
    parameter bit          USE_ACK     = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clka,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          ack,
    output logic          en,
    output logic [DW-1:0] data,
    output logic          done
);

    localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_GAP,
        S_REQ,
        S_RELEASE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    // ack synchronizer; ack_s is ack after SYNC_STAGES flops
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
        end
    end

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign in_ready = (state == S_IDLE);

    // Transfer FSM; en, data and done are all registered here
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
            en    <= 1'b0;
            data  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data <= in_data;
                        en   <= 1'b1;
                        if (USE_ACK) begin
                            state <= S_REQ;
                        end else begin
                            state <= S_HOLD;
                            cnt   <= CW'(HOLD - 1);
                        end
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        en    <= 1'b0;
                        state <= S_GAP;
                        cnt   <= CW'(GAP - 1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_REQ: begin
                    if (ack_s) begin
                        en    <= 1'b0;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!ack_s) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    en    <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sync_launcher.sv
// Bench for mux_sync_launcher: one open-loop instance (HOLD=12, GAP=6) and one
// closed-loop instance (USE_ACK=1, SYNC_STAGES=2) sharing clock and reset.
// Accepted words are queued when driven and popped when the launch is checked.
module tb_mux_sync_launcher;

    localparam int unsigned DW = 8;
    localparam int unsigned H  = 12;
    localparam int unsigned G  = 6;

    logic          clka = 1'b0;
    logic          rstn;
    logic          iv_a, rdy_a, ack_a, en_a, done_a;
    logic [DW-1:0] d_a, data_a;
    logic          iv_b, rdy_b, ack_b, en_b, done_b;
    logic [DW-1:0] d_b, data_b;

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clka = ~clka;

    mux_sync_launcher #(.DW(DW), .HOLD(H), .GAP(G), .USE_ACK(1'b0), .SYNC_STAGES(2)) u_ol (
        .clka(clka), .rstn(rstn), .in_valid(iv_a), .in_ready(rdy_a), .in_data(d_a),
        .ack(ack_a), .en(en_a), .data(data_a), .done(done_a)
    );

    mux_sync_launcher #(.DW(DW), .HOLD(H), .GAP(G), .USE_ACK(1'b1), .SYNC_STAGES(2)) u_cl (
        .clka(clka), .rstn(rstn), .in_valid(iv_b), .in_ready(rdy_b), .in_data(d_b),
        .ack(ack_b), .en(en_b), .data(data_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // Called at the first sample after an accept edge; walks HOLD+GAP+1 samples
    task automatic run_open(input logic [DW-1:0] exp, input bit toggle);
        for (int c = 1; c <= int'(H + G + 1); c++) begin
            check($sformatf("ol_c%0d", c), {en_a, rdy_a, done_a, data_a},
                  {1'(c <= int'(H)), 1'(c == int'(H + G + 1)), 1'(c == int'(H + G + 1)), exp});
            if (toggle && c <= int'(H + G)) begin
                iv_a  = 1'($urandom_range(0, 1));
                d_a   = DW'($urandom);
                ack_a = 1'($urandom_range(0, 1));
            end else if (toggle) begin
                iv_a  = 1'b0;
                ack_a = 1'b0;
            end
            if (c <= int'(H + G)) step();
        end
    endtask

    // Called at the first sample after an accept edge on the closed-loop instance
    task automatic run_ack(input logic [DW-1:0] exp);
        int n;
        check("cl_accept", {en_b, rdy_b, done_b, data_b}, {1'b1, 1'b0, 1'b0, exp});
        repeat (5) begin
            iv_b = 1'b1;
            d_b  = DW'($urandom);
            step();
            check("cl_req_hold", {en_b, rdy_b, data_b}, {1'b1, 1'b0, exp});
        end
        iv_b  = 1'b0;
        ack_b = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            check("cl_req_data", data_b, exp);
        end while (en_b && n < 10);
        // two synchronizer flops plus the FSM edge
        check("cl_en_fall_lat", n, 3);
        check("cl_release", {en_b, rdy_b, done_b, data_b}, {1'b0, 1'b0, 1'b0, exp});
        step();
        ack_b = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            check("cl_rel_en", en_b, 1'b0);
        end while (!done_b && n < 10);
        check("cl_done_lat", n, 3);
        check("cl_done", {rdy_b, done_b, data_b}, {1'b1, 1'b1, exp});
        step();
        check("cl_done_pulse", {rdy_b, done_b}, {1'b1, 1'b0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn  = 1'b0;
        iv_a  = 1'b0; d_a = '0; ack_a = 1'b0;
        iv_b  = 1'b0; d_b = '0; ack_b = 1'b0;

        // Reset then idle
        step();
        step();
        check("rst_a", {en_a, done_a, rdy_a, data_a}, {1'b0, 1'b0, 1'b1, 8'h00});
        check("rst_b", {en_b, done_b, rdy_b, data_b}, {1'b0, 1'b0, 1'b1, 8'h00});
        rstn = 1'b1;
        repeat (20) begin
            step();
            check("idle_a", {en_a, done_a, rdy_a, data_a}, {1'b0, 1'b0, 1'b1, 8'h00});
            check("idle_b", {en_b, done_b, rdy_b, data_b}, {1'b0, 1'b0, 1'b1, 8'h00});
        end

        // Single open-loop transfer, in_valid pulsed one cycle
        d_a = 8'h55; iv_a = 1'b1; q_a.push_back(8'h55);
        step();
        iv_a = 1'b0;
        run_open(q_a.pop_front(), 1'b0);
        step();
        check("ol_no_reaccept", {en_a, rdy_a}, {1'b0, 1'b1});

        // Back-to-back open-loop transfers, in_valid held high
        d_a = 8'h55; iv_a = 1'b1; q_a.push_back(8'h55);
        step();
        d_a = 8'hFF; q_a.push_back(8'hFF);
        run_open(q_a.pop_front(), 1'b0);
        step();
        d_a = 8'hAC; q_a.push_back(8'hAC);
        run_open(q_a.pop_front(), 1'b0);
        step();
        iv_a = 1'b0;
        run_open(q_a.pop_front(), 1'b0);
        step();
        check("b2b_drained", {en_a, rdy_a, done_a}, {1'b0, 1'b1, 1'b0});
        check("b2b_queue_empty", q_a.size(), 0);

        // Open-loop transfer with in_valid, in_data and ack toggling throughout
        d_a = 8'h3C; iv_a = 1'b1; q_a.push_back(8'h3C);
        step();
        run_open(q_a.pop_front(), 1'b1);
        step();

        // Closed-loop handshakes
        d_b = 8'hFF; iv_b = 1'b1; q_b.push_back(8'hFF);
        step();
        run_ack(q_b.pop_front());
        d_b = 8'hAC; iv_b = 1'b1; q_b.push_back(8'hAC);
        step();
        run_ack(q_b.pop_front());

        // Reset during HOLD aborts immediately with no done pulse
        d_a = 8'hAC; iv_a = 1'b1; q_a.push_back(8'hAC);
        step();
        iv_a = 1'b0;
        check("mid_accept", {en_a, data_a}, {1'b1, q_a.pop_front()});
        repeat (4) step();
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_async", {en_a, done_a, rdy_a, data_a}, {1'b0, 1'b0, 1'b1, 8'h00});
        step();
        rstn = 1'b1;
        repeat (H + G + 2) begin
            step();
            check("post_rst_idle", {en_a, done_a, rdy_a}, {1'b0, 1'b0, 1'b1});
        end
        d_a = 8'h55; iv_a = 1'b1; q_a.push_back(8'h55);
        step();
        iv_a = 1'b0;
        run_open(q_a.pop_front(), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
